// File: rtl/fe_simple_rx.sv
// Receive frontend: timestamps ADC samples, packs them into 64-bit words, writes fixed-length
// bursts into a RAM ring buffer (one host credit per burst) and emits one descriptor per burst.
module fe_simple_rx #(
  parameter int unsigned TIMESTAMP_BITS = 48,
  parameter int unsigned RAM_ADDR_WIDTH = 18,
  parameter int unsigned DATA_BITS      = 3,
  parameter int unsigned BURST_BITS     = 12,
  parameter int unsigned FIFO_LOG2      = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_enable,
  input  logic [1:0]                             cfg_format,
  input  logic [BURST_BITS-1:0]                  cfg_burst_words,
  input  logic [63:0]                            adc_data,
  input  logic                                   adc_valid,
  input  logic                                   s_buf_valid,
  output logic                                   s_buf_ready,
  output logic [RAM_ADDR_WIDTH-DATA_BITS-1:0]    m_ram_waddr,
  output logic [63:0]                            m_ram_wdata,
  output logic                                   m_ram_wvalid,
  input  logic                                   m_ram_wready,
  output logic [TIMESTAMP_BITS+BURST_BITS:0]     m_descr_data,
  output logic                                   m_descr_valid,
  input  logic                                   m_descr_ready,
  output logic                                   sig_overrun,
  output logic [31:0]                            stat_overruns,
  output logic [TIMESTAMP_BITS-1:0]              rx_timer
);

  localparam int unsigned AW    = RAM_ADDR_WIDTH - DATA_BITS;
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned PW    = FIFO_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } wr_entry_t;

  typedef struct packed {
    logic                      err;
    logic [TIMESTAMP_BITS-1:0] ts;
    logic [BURST_BITS-1:0]     words;
  } descr_t;

  state_t                    r_state, w_state_n;
  logic [TIMESTAMP_BITS-1:0] r_timer;
  logic                      r_phase;
  logic [31:0]               r_lo;
  logic [BURST_BITS-1:0]     r_len, r_cnt, w_len_n, w_cnt_n;
  logic [TIMESTAMP_BITS-1:0] r_ts, w_ts_n;
  logic                      r_err, w_err_n;
  logic [AW-1:0]             r_addr;
  wr_entry_t                 r_mem [DEPTH];
  logic [PW-1:0]             r_wp, r_rp, w_level;
  logic                      w_empty, w_full, w_pop, w_push, w_can_push;
  logic                      r_pend, r_dv;
  descr_t                    r_pend_d, w_cpl_d;
  logic                      w_cpl, w_descr_free, w_descr_ovr;
  logic                      w_start_ovr, w_full_ovr, w_ovr;
  logic                      w_addr_inc, w_buf_ready;
  logic                      r_ovr;
  logic [31:0]               r_ovr_cnt;
  logic                      w_fmt2, w_first, w_word_vld;
  logic [63:0]               w_word;

  // Packer: CI16_1 pairs two 32-bit samples, anything else is one sample per word
  assign w_fmt2     = (cfg_format != 2'd0);
  assign w_first    = cfg_enable && adc_valid && !r_phase;
  assign w_word_vld = cfg_enable && adc_valid && (w_fmt2 || r_phase);
  assign w_word     = w_fmt2 ? adc_data : {adc_data[31:0], r_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_phase <= 1'b0;
      r_lo    <= '0;
    end else if (!cfg_enable) begin
      r_timer <= '0;
      r_phase <= 1'b0;
    end else if (adc_valid) begin
      r_timer <= r_timer + TIMESTAMP_BITS'(1);
      if (!w_fmt2) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_lo <= adc_data[31:0];
      end
    end
  end

  // Write FIFO status; a full FIFO still accepts a push when the head pops in the same cycle
  assign w_level    = r_wp - r_rp;
  assign w_empty    = (r_wp == r_rp);
  assign w_full     = (w_level == PW'(DEPTH));
  assign w_pop      = !w_empty && m_ram_wready;
  assign w_can_push = !w_full || w_pop;

  assign w_descr_free = !r_pend || (r_dv && m_descr_ready);

  // Burst FSM next state; start-cycle values feed the word handling so a burst can begin on a word
  always_comb begin
    w_state_n   = r_state;
    w_len_n     = r_len;
    w_cnt_n     = r_cnt;
    w_ts_n      = r_ts;
    w_err_n     = r_err;
    w_buf_ready = 1'b0;
    w_push      = 1'b0;
    w_addr_inc  = 1'b0;
    w_start_ovr = 1'b0;
    w_full_ovr  = 1'b0;
    w_cpl       = 1'b0;
    w_cpl_d     = '0;

    case (r_state)
      S_IDLE: begin
        if (w_first) begin
          w_len_n = cfg_burst_words;
          w_cnt_n = '0;
          if (s_buf_valid) begin
            w_buf_ready = 1'b1;
            w_ts_n      = r_timer;
            w_err_n     = 1'b0;
            w_state_n   = S_ACTIVE;
          end else begin
            w_start_ovr = 1'b1;
            w_state_n   = S_DROP;
          end
        end
      end
      S_ACTIVE: begin
        if (!cfg_enable) begin
          w_cpl     = 1'b1;
          w_cpl_d   = '{err: 1'b1, ts: r_ts, words: r_cnt - BURST_BITS'(1)};
          w_state_n = S_IDLE;
        end
      end
      S_DROP: begin
        if (!cfg_enable) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_word_vld) begin
      if (w_state_n == S_ACTIVE) begin
        w_addr_inc = 1'b1;
        if (w_can_push) begin
          w_push = 1'b1;
        end else begin
          w_full_ovr = 1'b1;
          w_err_n    = 1'b1;
        end
        if (w_cnt_n == w_len_n) begin
          w_cpl     = 1'b1;
          w_cpl_d   = '{err: w_err_n, ts: w_ts_n, words: w_len_n};
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = w_cnt_n + BURST_BITS'(1);
        end
      end else if (w_state_n == S_DROP) begin
        if (w_cnt_n == w_len_n) w_state_n = S_IDLE;
        else                    w_cnt_n   = w_cnt_n + BURST_BITS'(1);
      end
    end
  end

  assign w_descr_ovr = w_cpl && !w_descr_free;
  assign w_ovr       = w_start_ovr || w_full_ovr || w_descr_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_ts    <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_n;
      r_len   <= w_len_n;
      r_cnt   <= w_cnt_n;
      r_ts    <= w_ts_n;
      r_err   <= w_err_n;
      if (w_addr_inc) r_addr <= r_addr + AW'(1);
    end
  end

  // Write FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp[FIFO_LOG2-1:0]] <= '{addr: r_addr, data: w_word};
        r_wp <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
    end
  end

  // Descriptor: pending until its words have drained, then offered and held until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= 1'b0;
      r_pend_d <= '0;
      r_dv     <= 1'b0;
    end else begin
      if (r_dv && m_descr_ready) begin
        r_dv   <= 1'b0;
        r_pend <= 1'b0;
      end else if (r_pend && w_empty && !r_dv) begin
        r_dv <= 1'b1;
      end
      if (w_cpl && w_descr_free) begin
        r_pend   <= 1'b1;
        r_pend_d <= w_cpl_d;
      end
    end
  end

  // Overrun sources in the same cycle collapse into one event
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr     <= 1'b0;
      r_ovr_cnt <= '0;
    end else begin
      r_ovr <= w_ovr;
      if (w_ovr) r_ovr_cnt <= r_ovr_cnt + 32'd1;
    end
  end

  assign s_buf_ready   = w_buf_ready;
  assign m_ram_wvalid  = !w_empty;
  assign m_ram_waddr   = r_mem[r_rp[FIFO_LOG2-1:0]].addr;
  assign m_ram_wdata   = r_mem[r_rp[FIFO_LOG2-1:0]].data;
  assign m_descr_data  = r_pend_d;
  assign m_descr_valid = r_dv;
  assign sig_overrun   = r_ovr;
  assign stat_overruns = r_ovr_cnt;
  assign rx_timer      = r_timer;

endmodule

// File: tb/tb_fe_simple_rx.sv
// Scoreboard bench for fe_simple_rx: expected RAM writes and descriptors are queued as samples
// are driven and compared when the DUT hands them over.
module tb_fe_simple_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [1:0]  cfg_format;
  logic [11:0] cfg_burst_words;
  logic [63:0] adc_data;
  logic        adc_valid;
  logic        s_buf_valid;
  logic        s_buf_ready;
  logic [14:0] m_ram_waddr;
  logic [63:0] m_ram_wdata;
  logic        m_ram_wvalid;
  logic        m_ram_wready;
  logic [60:0] m_descr_data;
  logic        m_descr_valid;
  logic        m_descr_ready;
  logic        sig_overrun;
  logic [31:0] stat_overruns;
  logic [47:0] rx_timer;

  fe_simple_rx dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_format(cfg_format),
    .cfg_burst_words(cfg_burst_words), .adc_data(adc_data), .adc_valid(adc_valid),
    .s_buf_valid(s_buf_valid), .s_buf_ready(s_buf_ready),
    .m_ram_waddr(m_ram_waddr), .m_ram_wdata(m_ram_wdata), .m_ram_wvalid(m_ram_wvalid),
    .m_ram_wready(m_ram_wready), .m_descr_data(m_descr_data), .m_descr_valid(m_descr_valid),
    .m_descr_ready(m_descr_ready), .sig_overrun(sig_overrun), .stat_overruns(stat_overruns),
    .rx_timer(rx_timer)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          ovr_exp  = 0;
  int          ovr_pulses = 0;
  int          bufrdy_pulses = 0;
  logic [78:0] q_wr [$];
  logic [60:0] q_ds [$];
  logic [78:0] mon_w;
  logic [60:0] mon_d;
  logic [14:0] exp_addr;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Observe handshakes on the falling edge, where inputs and outputs are settled
  always @(negedge clk) begin
    if (!rst) begin
      if (m_ram_wvalid && m_ram_wready) begin
        if (q_wr.size() == 0) chk("wr_unexpected", 128'(q_wr.size()), 128'(1));
        else begin
          mon_w = q_wr.pop_front();
          chk("wr", 128'({m_ram_waddr, m_ram_wdata}), 128'(mon_w));
        end
      end
      if (m_descr_valid && m_descr_ready) begin
        if (q_ds.size() == 0) chk("descr_unexpected", 128'(q_ds.size()), 128'(1));
        else begin
          mon_d = q_ds.pop_front();
          chk("descr", 128'(m_descr_data), 128'(mon_d));
        end
      end
      if (sig_overrun) ovr_pulses++;
      if (s_buf_ready) bufrdy_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_w(input logic [63:0] d);
    q_wr.push_back({exp_addr, d});
    exp_addr = exp_addr + 15'd1;
  endtask

  task automatic exp_d(input logic e, input logic [47:0] ts, input logic [11:0] w);
    q_ds.push_back({e, ts, w});
  endtask

  task automatic send(input logic [63:0] d, input int gap);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int k = 0; k < limit && (q_wr.size() != 0 || q_ds.size() != 0 ||
                                  m_ram_wvalid || m_descr_valid); k++) tick();
    chk(tag, 128'(q_wr.size() + q_ds.size()), 128'(0));
  endtask

  task automatic disable_rx();
    cfg_enable = 1'b0;
    tick();
    tick();
  endtask

  logic [47:0] fts;
  int          n, chunk;

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; cfg_format = 2'd0; cfg_burst_words = '0;
    adc_data = '0; adc_valid = 1'b0; s_buf_valid = 1'b0;
    m_ram_wready = 1'b1; m_descr_ready = 1'b1; exp_addr = '0;
    repeat (3) tick();
    chk("rst_timer",   128'(rx_timer), 128'(0));
    chk("rst_wvalid",  128'(m_ram_wvalid), 128'(0));
    chk("rst_dvalid",  128'(m_descr_valid), 128'(0));
    chk("rst_ovr",     128'({sig_overrun, stat_overruns}), 128'(0));
    chk("rst_bufrdy",  128'(s_buf_ready), 128'(0));
    chk("rst_ramout",  128'({m_ram_waddr, m_ram_wdata, m_descr_data}), 128'(0));
    rst = 1'b0;
    tick();

    // 1: CI16_2, 4-word bursts, credit always present
    cfg_format = 2'd1; cfg_burst_words = 12'd3; s_buf_valid = 1'b1; cfg_enable = 1'b1;
    bufrdy_pulses = 0;
    exp_d(1'b0, 48'd0, 12'd3);
    exp_d(1'b0, 48'd4, 12'd3);
    for (int i = 0; i < 8; i++) begin
      exp_w(64'hA5A5_0000_0000_0000 | 64'(i));
      send(64'hA5A5_0000_0000_0000 | 64'(i), 1);
    end
    wait_drain("t1_drain", 50);
    chk("t1_timer",  128'(rx_timer), 128'(8));
    chk("t1_bufrdy", 128'(bufrdy_pulses), 128'(2));
    disable_rx();

    // 2: CI16_1 packing, upper adc bits must be ignored
    cfg_format = 2'd0; cfg_burst_words = 12'd1; cfg_enable = 1'b1;
    exp_d(1'b0, 48'd0, 12'd1);
    exp_w(64'h00000022_00000011);
    exp_w(64'h00000044_00000033);
    send({32'hDEADBEEF, 32'h11}, 1);
    send({32'hDEADBEEF, 32'h22}, 1);
    send({32'hDEADBEEF, 32'h33}, 1);
    send({32'hDEADBEEF, 32'h44}, 1);
    wait_drain("t2_drain", 50);
    disable_rx();

    // 3: no credit at the first burst, so its two words are dropped
    cfg_format = 2'd1; cfg_burst_words = 12'd1; s_buf_valid = 1'b0; cfg_enable = 1'b1;
    bufrdy_pulses = 0;
    ovr_exp += 1;
    exp_d(1'b0, 48'd2, 12'd1);
    send(64'h3333_0000_0000_0000, 1);
    s_buf_valid = 1'b1;
    send(64'h3333_0000_0000_0001, 1);
    exp_w(64'h3333_0000_0000_0002);
    exp_w(64'h3333_0000_0000_0003);
    send(64'h3333_0000_0000_0002, 1);
    send(64'h3333_0000_0000_0003, 1);
    wait_drain("t3_drain", 50);
    chk("t3_ovr",    128'(stat_overruns), 128'(ovr_exp));
    chk("t3_bufrdy", 128'(bufrdy_pulses), 128'(1));
    disable_rx();

    // 4: RAM stalls for 10 cycles during a 6-word burst; words 4 and 5 overflow the FIFO
    cfg_format = 2'd1; cfg_burst_words = 12'd5; cfg_enable = 1'b1; m_ram_wready = 1'b0;
    ovr_exp += 2;
    exp_d(1'b1, 48'd0, 12'd5);
    for (int i = 0; i < 4; i++) exp_w(64'h4444_0000_0000_0000 | 64'(i));
    exp_addr = exp_addr + 15'd2;
    for (int i = 0; i < 6; i++) send(64'h4444_0000_0000_0000 | 64'(i), 0);
    repeat (4) tick();
    chk("t4_hold_dvalid", 128'(m_descr_valid), 128'(0));
    chk("t4_hold_q",      128'(q_wr.size()), 128'(4));
    m_ram_wready = 1'b1;
    for (int k = 0; k < 20 && !m_descr_valid; k++) tick();
    chk("t4_dvalid",  128'(m_descr_valid), 128'(1));
    chk("t4_drained", 128'(q_wr.size()), 128'(0));
    wait_drain("t4_drain", 50);
    chk("t4_ovr", 128'(stat_overruns), 128'(ovr_exp));
    disable_rx();

    // 5: descriptor not accepted across two bursts; the second descriptor is dropped
    cfg_format = 2'd1; cfg_burst_words = 12'd1; cfg_enable = 1'b1; m_descr_ready = 1'b0;
    ovr_exp += 1;
    exp_d(1'b0, 48'd0, 12'd1);
    for (int i = 0; i < 4; i++) begin
      exp_w(64'h5555_0000_0000_0000 | 64'(i));
      send(64'h5555_0000_0000_0000 | 64'(i), 1);
    end
    repeat (2) tick();
    chk("t5_hold_a", 128'({m_descr_valid, m_descr_data}), 128'({1'b1, 1'b0, 48'd0, 12'd1}));
    repeat (3) tick();
    chk("t5_hold_b", 128'({m_descr_valid, m_descr_data}), 128'({1'b1, 1'b0, 48'd0, 12'd1}));
    chk("t5_ovr", 128'(stat_overruns), 128'(ovr_exp));
    m_descr_ready = 1'b1;
    wait_drain("t5_drain", 50);
    disable_rx();

    // Advance the address counter to 0x7FFE with long bursts
    cfg_format = 2'd1; cfg_enable = 1'b1; fts = '0;
    while (exp_addr != 15'h7FFE) begin
      n     = 32766 - int'(exp_addr);
      chunk = (n > 4096) ? 4096 : n;
      cfg_burst_words = 12'(chunk - 1);
      exp_d(1'b0, fts, 12'(chunk - 1));
      for (int i = 0; i < chunk; i++) begin
        exp_w({16'hF111, fts + 48'(i)});
        send({16'hF111, fts + 48'(i)}, 0);
      end
      fts = fts + 48'(chunk);
      wait_drain("fill_drain", 40);
    end
    disable_rx();

    // 6: address wrap, then abort after two words of the next burst
    cfg_format = 2'd1; cfg_burst_words = 12'd3; cfg_enable = 1'b1;
    exp_d(1'b0, 48'd0, 12'd3);
    exp_d(1'b1, 48'd4, 12'd1);
    for (int i = 0; i < 6; i++) begin
      exp_w(64'h6666_0000_0000_0000 | 64'(i));
      send(64'h6666_0000_0000_0000 | 64'(i), 1);
    end
    cfg_enable = 1'b0;
    tick();
    chk("t6_timer", 128'(rx_timer), 128'(0));
    wait_drain("t6_drain", 50);

    chk("end_ovr_cnt",    128'(stat_overruns), 128'(ovr_exp));
    chk("end_ovr_pulses", 128'(ovr_pulses), 128'(ovr_exp));
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errs);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fe_simple_rx.md
Name: fe_simple_rx

Overview:
Receive-side frontend, the counterpart of the TX frontend. It timestamps ADC samples and packs them into 64-bit RAM words. It writes fixed-length bursts into a ring buffer in RAM, one host-provided buffer credit per burst, and emits one completion descriptor per burst carrying the first-sample timestamp. It sits between the ADC sample stream and the RAM write port / DMA descriptor path, in a single clock domain.

Parameters:
TIMESTAMP_BITS, 48, width of sample timer and descriptor timestamp
RAM_ADDR_WIDTH, 18, RAM byte-address width
DATA_BITS, 3, log2 of bytes per RAM word (DATA_WIDTH = 8 << DATA_BITS = 64)
BURST_BITS, 12, width of burst-length field (words minus 1)
FIFO_LOG2, 2, log2 depth of internal write FIFO

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_enable  in  1  0 = timer cleared, packer and burst FSM idle
cfg_format  in  2  0 = CI16_1 (32-bit sample), 1 = CI16_2 (64-bit sample); 2,3 treated as 1
cfg_burst_words  in  BURST_BITS  words per burst minus 1; sampled at burst start
adc_data  in  64  sample; CI16_1 uses [31:0]
adc_valid  in  1  sample strobe, no backpressure
s_buf_valid  in  1  free-buffer credit available
s_buf_ready  out  1  credit consumed (1-cycle pulse)
m_ram_waddr  out  RAM_ADDR_WIDTH-DATA_BITS  word address
m_ram_wdata  out  64  word data
m_ram_wvalid  out  1  write request
m_ram_wready  in  1  write accept
m_descr_data  out  1+TIMESTAMP_BITS+BURST_BITS  {err, ts, words-1}
m_descr_valid  out  1  descriptor valid
m_descr_ready  in  1  descriptor accept
sig_overrun  out  1  1-cycle pulse per overrun event
stat_overruns  out  32  overrun counter, wraps
rx_timer  out  TIMESTAMP_BITS  samples received since enable

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; address counter 0; packer phase 0.
- rx_timer: 0 while !cfg_enable. Otherwise increments by 1 on each adc_valid, wrapping modulo 2^TIMESTAMP_BITS.
- Packer:
  - CI16_1: first valid sample goes to word[31:0], second to word[63:32]; the word is produced on the second sample.
  - CI16_2: every valid sample produces word = adc_data.
  - Phase is cleared when !cfg_enable. cfg_format may change only while disabled.
- Burst FSM states: IDLE, ACTIVE, DROP.
  - IDLE: at the first sample of a new word (phase 0), with cfg_enable and adc_valid:
    - If s_buf_valid: pulse s_buf_ready in the same cycle; latch ts = rx_timer (timestamp of that sample) and len = cfg_burst_words; clear word count and err; go ACTIVE.
    - Else: pulse sig_overrun; stat_overruns +1; go DROP.
  - ACTIVE: each produced word is pushed to the FIFO together with the current address; the address increments.
    - If the FIFO is full, the word is discarded, but the address still increments, err is set, and the overrun is counted and pulsed.
    - On word count == len: latch the descriptor into the pending register; go IDLE. A new burst may start on the next sample.
  - DROP: discard len+1 words, then go IDLE. Address does not advance.
- Address counter: word granularity; wraps at 2^(RAM_ADDR_WIDTH-DATA_BITS) with no special handling.
- FIFO: 2^FIFO_LOG2 entries of {addr, data}.
  - m_ram_wvalid = FIFO not empty; head pops on wvalid && wready.
  - Simultaneous push and pop when full is allowed: the push succeeds.
- Descriptor path:
  - The pending register holds {err, ts, len}.
  - m_descr_valid asserts the cycle after pending && FIFO empty, i.e. all burst words have been accepted by RAM.
  - It is held stable until m_descr_ready; then it clears and pending clears.
  - If a burst completes while the pending register or the output is still occupied, the new descriptor is dropped and an overrun is counted and pulsed. Its credit stays consumed.
- cfg_enable falling during ACTIVE aborts the burst: the descriptor is latched with err = 1 and words = written-1. Abort with zero words written emits err = 1, words = all-ones.
- Simultaneous overrun sources in one cycle count as 1.
- rst mid-burst: immediate return to reset state; FIFO contents and pending descriptor are discarded.

Test Plan:
1. CI16_2, burst_words = 3, credit always valid, 8 samples from timer 0 → 8 writes at addr 0..7 with data = samples. Descriptors {0, ts = 0, 3} then {0, ts = 4, 3}. Two s_buf_ready pulses.
2. CI16_1, burst_words = 1, samples 0x11, 0x22, 0x33, 0x44 → words 0x00000022_00000011 and 0x00000044_00000033. One descriptor {0, ts = 0, 1}.
3. Credit absent at first burst, present afterwards; CI16_2, burst_words = 1 → first 2 samples dropped; stat_overruns = 1. The next burst is written at addr 0 with ts = 2.
4. m_ram_wready = 0 for 10 cycles during a 6-word burst, FIFO depth 4 → words 4 and 5 dropped, addresses 4 and 5 skipped; descriptor err = 1; stat_overruns = 2; descriptor valid only after the FIFO drains.
5. m_descr_ready held 0 across two completed bursts → the first descriptor is held stable and the second is dropped; stat_overruns = 1.
6. Address start 2^15-2, CI16_2, burst_words = 3 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001. cfg_enable dropped after 2 words of the next burst → descriptor err = 1, words = 1; rx_timer reads 0.
